// File: rtl/frost32_fetch_sequencer.sv
// Frost32 fetch/stall sequencer: owns the shared memory port, holds the PC and the
// fetch latch, and time-shares the port between instruction fetch and load/store.
module frost32_fetch_sequencer #(
    parameter logic [31:0] RESET_PC          = 32'h0000_0000,
    parameter int          CTRL_FLOW_BUBBLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  dec_group,
    input  logic        dec_causes_stall,
    input  logic [1:0]  dec_ldst_type,
    input  logic [31:0] ex_ldst_addr,
    input  logic [31:0] ex_store_data,
    input  logic        ex_cf_resolved,
    input  logic        ex_cf_taken,
    input  logic [31:0] ex_cf_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid
);

    typedef enum logic [2:0] {
        RST_IDLE,
        FETCH,
        DECODE,
        DATA,
        CTRL_WAIT
    } state_t;

    localparam logic [3:0] BUBBLE_LOAD = 4'(CTRL_FLOW_BUBBLES - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [3:0]  bubble_cnt;
    logic        cf_res;
    logic        cf_taken;
    logic [31:0] cf_target;
    logic        cf_exit;
    logic        exit_taken;
    logic [31:0] exit_target;

    // A resolution pulse arriving in the exit cycle overrides the sticky copy.
    assign cf_exit     = (state == CTRL_WAIT) && (bubble_cnt == 4'd0) && (cf_res || ex_cf_resolved);
    assign exit_taken  = ex_cf_resolved ? ex_cf_taken  : cf_taken;
    assign exit_target = ex_cf_resolved ? ex_cf_target : cf_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RST_IDLE:  state_next = FETCH;
            FETCH:     if (mem_ack) state_next = DECODE;
            DECODE: begin
                if (!dec_causes_stall) begin
                    state_next = FETCH;
                end else if (dec_group == 4'd5) begin
                    state_next = DATA;
                end else begin
                    state_next = CTRL_WAIT;
                end
            end
            DATA:      if (mem_ack) state_next = FETCH;
            CTRL_WAIT: if (cf_exit) state_next = FETCH;
            default:   state_next = RST_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = 32'h0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        stall     = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            DECODE: stall = 1'b1;
            DATA: begin
                mem_req   = 1'b1;
                mem_addr  = ex_ldst_addr;
                mem_we    = dec_ldst_type[1];
                mem_wdata = ex_store_data;
                stall     = 1'b1;
            end
            CTRL_WAIT: stall = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr_out   <= 32'h0;
            pc_out      <= 32'h0;
            instr_valid <= 1'b0;
            ld_data     <= 32'h0;
            ld_valid    <= 1'b0;
            bubble_cnt  <= 4'd0;
            cf_res      <= 1'b0;
            cf_taken    <= 1'b0;
            cf_target   <= 32'h0;
        end else begin
            instr_valid <= 1'b0;
            ld_valid    <= 1'b0;
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        instr_out   <= mem_rdata;
                        pc_out      <= pc;
                        pc          <= pc + 32'd4;
                        instr_valid <= 1'b1;
                    end
                end
                DECODE: begin
                    if (dec_causes_stall && (dec_group != 4'd5)) begin
                        bubble_cnt <= BUBBLE_LOAD;
                    end
                end
                DATA: begin
                    if (mem_ack && !dec_ldst_type[1]) begin
                        ld_data  <= mem_rdata;
                        ld_valid <= 1'b1;
                    end
                end
                CTRL_WAIT: begin
                    if (cf_exit) begin
                        // Not-taken needs no update: pc already points past the branch.
                        if (exit_taken) begin
                            pc <= exit_target;
                        end
                        cf_res    <= 1'b0;
                        cf_taken  <= 1'b0;
                        cf_target <= 32'h0;
                    end else begin
                        if (bubble_cnt != 4'd0) begin
                            bubble_cnt <= bubble_cnt - 4'd1;
                        end
                        if (ex_cf_resolved) begin
                            cf_res    <= 1'b1;
                            cf_taken  <= ex_cf_taken;
                            cf_target <= ex_cf_target;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frost32_fetch_sequencer.sv
// Directed bench for frost32_fetch_sequencer: fetch cadence, load/store, control-flow
// waits, ignored out-of-place resolution pulses, mid-access reset and PC wrap-around.
module tb_frost32_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  dec_group = 4'd0;
    logic        dec_causes_stall = 1'b0;
    logic [1:0]  dec_ldst_type = 2'b00;
    logic [31:0] ex_ldst_addr = 32'h0;
    logic [31:0] ex_store_data = 32'h0;
    logic        ex_cf_resolved = 1'b0;
    logic        ex_cf_taken = 1'b0;
    logic [31:0] ex_cf_target = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;

    int total = 0;
    int bad = 0;

    frost32_fetch_sequencer #(
        .RESET_PC(32'h0000_0100),
        .CTRL_FLOW_BUBBLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dec_group(dec_group),
        .dec_causes_stall(dec_causes_stall),
        .dec_ldst_type(dec_ldst_type),
        .ex_ldst_addr(ex_ldst_addr),
        .ex_store_data(ex_store_data),
        .ex_cf_resolved(ex_cf_resolved),
        .ex_cf_taken(ex_cf_taken),
        .ex_cf_target(ex_cf_target),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .instr_out(instr_out),
        .instr_valid(instr_valid),
        .pc_out(pc_out),
        .stall(stall),
        .ld_data(ld_data),
        .ld_valid(ld_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Zero-wait fetch from the FETCH cycle through DECODE, leaving the DUT in the next state.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] instr,
                                 input logic stall_flag, input logic [3:0] grp, input logic [1:0] ldst);
        checkOutput("fetch_req", 32'(mem_req), 32'd1);
        checkOutput("fetch_addr", mem_addr, addr);
        checkOutput("fetch_we", 32'(mem_we), 32'd0);
        checkOutput("fetch_stall", 32'(stall), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = instr;
        tick();
        mem_ack = 1'b0;
        checkOutput("dec_valid", 32'(instr_valid), 32'd1);
        checkOutput("dec_instr", instr_out, instr);
        checkOutput("dec_pc", pc_out, addr);
        checkOutput("dec_stall", 32'(stall), 32'd1);
        checkOutput("dec_req", 32'(mem_req), 32'd0);
        dec_causes_stall = stall_flag;
        dec_group = grp;
        dec_ldst_type = ldst;
        tick();
    endtask

    task automatic pulseResolve(input logic taken, input logic [31:0] target);
        ex_cf_resolved = 1'b1;
        ex_cf_taken = taken;
        ex_cf_target = target;
        tick();
        ex_cf_resolved = 1'b0;
        ex_cf_taken = 1'b0;
        ex_cf_target = 32'hDEAD_0000;
    endtask

    initial begin
        $display("[TB] start");
        #2 rst_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_instr", instr_out, 32'h0);
        checkOutput("rst_pc_out", pc_out, 32'h0);
        checkOutput("rst_ld_data", ld_data, 32'h0);
        checkOutput("rst_ivalid", 32'(instr_valid), 32'd0);
        checkOutput("rst_lvalid", 32'(ld_valid), 32'd0);
        rst_n = 1'b1;
        checkOutput("idle_req", 32'(mem_req), 32'd0);
        tick();

        // Three non-stalling instructions, the last one a group above 5.
        applyStimulus(32'h100, 32'h1111_0001, 1'b0, 4'd0, 2'b00);
        checkOutput("ivalid_pulse", 32'(instr_valid), 32'd0);
        applyStimulus(32'h104, 32'h1111_0002, 1'b0, 4'd3, 2'b00);
        applyStimulus(32'h108, 32'h1111_0003, 1'b0, 4'd7, 2'b00);

        // Load with the acknowledge on the third DATA cycle.
        ex_ldst_addr = 32'h2000;
        applyStimulus(32'h10C, 32'h2222_0000, 1'b1, 4'd5, 2'b00);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ld_req", 32'(mem_req), 32'd1);
            checkOutput("ld_addr", mem_addr, 32'h2000);
            checkOutput("ld_we", 32'(mem_we), 32'd0);
            checkOutput("ld_stall", 32'(stall), 32'd1);
            if (i == 2) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        mem_ack = 1'b0;
        checkOutput("ld_valid", 32'(ld_valid), 32'd1);
        checkOutput("ld_data", ld_data, 32'hDEAD_BEEF);
        applyStimulus(32'h110, 32'h1111_0004, 1'b0, 4'd0, 2'b00);
        checkOutput("ld_valid_once", 32'(ld_valid), 32'd0);

        // Store.
        ex_ldst_addr = 32'h3000;
        ex_store_data = 32'h1234_5678;
        applyStimulus(32'h114, 32'h3333_0000, 1'b1, 4'd5, 2'b10);
        checkOutput("st_req", 32'(mem_req), 32'd1);
        checkOutput("st_addr", mem_addr, 32'h3000);
        checkOutput("st_we", 32'(mem_we), 32'd1);
        checkOutput("st_wdata", mem_wdata, 32'h1234_5678);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("st_no_lvalid", 32'(ld_valid), 32'd0);
        checkOutput("st_ld_data_kept", ld_data, 32'hDEAD_BEEF);

        // Jump to 0x200, resolved on the first wait cycle.
        applyStimulus(32'h118, 32'h4444_0000, 1'b1, 4'd1, 2'b00);
        pulseResolve(1'b1, 32'h200);
        checkOutput("cf1_stall", 32'(stall), 32'd1);
        checkOutput("cf1_req", 32'(mem_req), 32'd0);
        tick();

        // Branch at 0x200 taken to 0x400.
        applyStimulus(32'h200, 32'h4444_0001, 1'b1, 4'd2, 2'b00);
        pulseResolve(1'b1, 32'h400);
        checkOutput("cf2_sticky_stall", 32'(stall), 32'd1);
        tick();

        // Late resolution: five idle wait cycles, then a taken pulse back to 0x200.
        applyStimulus(32'h400, 32'h4444_0002, 1'b1, 4'd2, 2'b00);
        for (int i = 0; i < 5; i++) begin
            checkOutput("late_stall", 32'(stall), 32'd1);
            tick();
        end
        pulseResolve(1'b1, 32'h200);

        // Branch at 0x200 not taken.
        applyStimulus(32'h200, 32'h4444_0003, 1'b1, 4'd2, 2'b00);
        pulseResolve(1'b0, 32'h600);
        checkOutput("nt_stall", 32'(stall), 32'd1);
        tick();

        // A resolution pulse during FETCH must not satisfy the following wait.
        ex_cf_resolved = 1'b1;
        ex_cf_taken = 1'b1;
        ex_cf_target = 32'h7770;
        checkOutput("ign_addr", mem_addr, 32'h204);
        mem_ack = 1'b1;
        mem_rdata = 32'h4444_0004;
        tick();
        mem_ack = 1'b0;
        ex_cf_resolved = 1'b0;
        ex_cf_taken = 1'b0;
        dec_causes_stall = 1'b1;
        dec_group = 4'd1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("ign_stall", 32'(stall), 32'd1);
            tick();
        end
        pulseResolve(1'b0, 32'h900);

        // Reset during the DATA wait.
        ex_ldst_addr = 32'h5000;
        applyStimulus(32'h208, 32'h2222_0001, 1'b1, 4'd5, 2'b00);
        checkOutput("rd_req_before", 32'(mem_req), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rd_req_async", 32'(mem_req), 32'd0);
        checkOutput("rd_stall", 32'(stall), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        checkOutput("rd_no_lvalid", 32'(ld_valid), 32'd0);
        checkOutput("rd_no_ivalid", 32'(instr_valid), 32'd0);
        checkOutput("rd_ld_data", ld_data, 32'h0);
        checkOutput("rd_pc_out", pc_out, 32'h0);
        mem_ack = 1'b0;
        rst_n = 1'b1;
        tick();

        // PC wrap-around from 0xFFFFFFFC.
        applyStimulus(32'h100, 32'h4444_0005, 1'b1, 4'd3, 2'b00);
        pulseResolve(1'b1, 32'hFFFF_FFFC);
        tick();
        applyStimulus(32'hFFFF_FFFC, 32'h1111_0005, 1'b0, 4'd0, 2'b00);
        checkOutput("wrap_addr", mem_addr, 32'h0);
        checkOutput("wrap_req", 32'(mem_req), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
